pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter stage of the multi-cycle CPU. Holds the PC and latches PC+4 at fetch. Computes and registers the branch target during decode, and forms the jump address. Loads the next PC under controller write strobes. Sits between the controller/ALU flags and instruction memory; its PC output addresses the fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset; must be word-aligned
- Clk  in  1  clock; all state updates on the rising edge
- Clrn  in  1  asynchronous active-low reset
- IRWr  in  1  fetch strobe: the instruction on Instr is captured this cycle
- Instr  in  32  instruction word from memory
- TgtWr  in  1  decode strobe: latch the branch target
- PCWr  in  1  unconditional PC write
- PCWrCond  in  1  conditional (branch) PC write
- Zero  in  1  ALU zero flag
- BrNe  in  1  1 = bne semantics, 0 = beq
- PCSrc  in  2  next-PC select: 00 PC+4, 01 Target, 10 JAddr, 11 RegA
- RegA  in  32  rs value for jr
- PC  out  32  current PC
- PCAdd4  out  32  latched PC+4 of the current instruction
- Target  out  32  registered branch target
- JAddr  out  32  jump address {PCAdd4[31:28], imm26, 2'b00}
- Phase  out  2  FSM state: 0 FETCH, 1 DECODE, 2 EXEC
- AddrErr  out  1  sticky misaligned-PC error

## Operation
- FSM:
  - FETCH -(IRWr)-> DECODE
  - DECODE -(TgtWr)-> EXEC
  - IRWr in any state goes to DECODE, which covers instructions that skip TgtWr.
  - State 3 is unreachable; if entered, it goes to FETCH.
- On IRWr:
  - PCAdd4 <= PC+4, computed from the current PC, mod 2^32.
  - imm26 <= Instr[25:0] and imm16 <= Instr[15:0], both held internally.
- On TgtWr in DECODE: Target <= PCAdd4 + (sext(imm16) << 2), mod 2^32. TgtWr in FETCH or EXEC is ignored and Target is held.
- PC load condition: load = PCWr | (PCWrCond & (Zero ^ BrNe)).
- Next-PC source:
  - PCSrc=00 uses the combinational PC+4 of the current PC. It is not the latched PCAdd4, so IRWr and PCWr in the same cycle work.
  - PCSrc=01 uses the current Target register.
  - PCSrc=10 uses JAddr.
  - PCSrc=11 uses RegA.
- Misalignment: if load is active and the selected value has [1:0] != 0, the PC holds and AddrErr <= 1. AddrErr clears only on reset. Only RegA can produce this.
- PCWr and PCWrCond together: PCWr wins, so the load is unconditional.
- Reset values (asynchronous, immediate):
  - PC = RESET_PC
  - PCAdd4 = RESET_PC+4
  - Target = 0
  - imm26 = imm16 = 0
  - Phase = FETCH
  - AddrErr = 0
- Reset mid-instruction discards all latched state.

## Timing
- All outputs are registered. JAddr is a wire concatenation of registers, so it is glitch-free after the edge.
- IRWr sampled at edge n: PCAdd4 and Phase are valid after edge n.
- TgtWr at edge n: Target is valid after edge n and usable for PCSrc=01 from cycle n+1.
- PC load is visible one edge after the strobe; zero added latency.
- Strobes are level-sampled every edge. The controller must pulse them for one cycle per event.
- PC+4 wrap: 0xFFFF_FFFC -> 0x0000_0000. The branch add wraps the same way.

## Structure
- Shared package `cpu_pkg`:
  - Phase encodings PH_FETCH=2'd0, PH_DECODE=2'd1, PH_EXEC=2'd2
  - PCSrc encodings PCS_ADD4, PCS_BR, PCS_J, PCS_JR
  - the constant WORD_BYTES=4
- One natural sub-module, `br_target_calc`: combinational, imm16 and PCAdd4 -> sext, shift left 2, add. Instantiate it once. The FSM, registers and next-PC mux stay in the top.

## Test plan
- Reset: hold Clrn=0 with random strobes -> PC=0x0000_0000, PCAdd4=0x4, Phase=0, AddrErr=0. Assert Clrn=0 mid-DECODE -> the same values immediately, without waiting for an edge.
- Fetch: PC=0x100; IRWr=1, PCWr=1, PCSrc=00 -> PC=0x104, PCAdd4=0x104, Phase=1.
- Branch: PCAdd4=0x104, imm16=0xFFFF; TgtWr -> Target=0x100, Phase=2. Then:
  - PCWrCond=1, Zero=1, BrNe=0, PCSrc=01 -> PC=0x100.
  - Same with Zero=0 -> PC unchanged.
  - BrNe=1, Zero=0 -> PC=0x100.
- Jump: PCAdd4=0x4000_0104, imm26=0x000_0040; PCWr, PCSrc=10 -> PC=0x4000_0100.
- JR misaligned: RegA=0x0000_0202, PCWr, PCSrc=11 -> PC unchanged, AddrErr=1. A later aligned jr to 0x200 -> PC=0x200 and AddrErr still 1.
- Wrap: PC=0xFFFF_FFFC; IRWr+PCWr, PCSrc=00 -> PC=0, PCAdd4=0. TgtWr pulsed in FETCH -> Target unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FSM phase and next-PC select encodings, word size.
// Latency: n/a (definitions only). Backpressure: n/a.
// Also provides the word-increment helper used by the PC stage.
package cpu_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        PH_FETCH  = 2'd0,
        PH_DECODE = 2'd1,
        PH_EXEC   = 2'd2,
        PH_BAD    = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        PCS_ADD4 = 2'd0,
        PCS_BR   = 2'd1,
        PCS_J    = 2'd2,
        PCS_JR   = 2'd3
    } pcsrc_e;

    function automatic logic [31:0] word_inc(input logic [31:0] a);
        return a + 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Controller <-> PC-stage bundle: strobes, flags and operands in; PC state out.
// Latency: n/a (wires only). Backpressure: none; strobes are level-sampled each edge.
// The master is the controller side, the slave is pc_sequencer.
interface pc_sequencer_if;
    logic        IRWr;
    logic [31:0] Instr;
    logic        TgtWr;
    logic        PCWr;
    logic        PCWrCond;
    logic        Zero;
    logic        BrNe;
    logic [1:0]  PCSrc;
    logic [31:0] RegA;
    logic [31:0] PC;
    logic [31:0] PCAdd4;
    logic [31:0] Target;
    logic [31:0] JAddr;
    logic [1:0]  Phase;
    logic        AddrErr;

    modport master (
        output IRWr, Instr, TgtWr, PCWr, PCWrCond, Zero, BrNe, PCSrc, RegA,
        input  PC, PCAdd4, Target, JAddr, Phase, AddrErr
    );

    modport slave (
        input  IRWr, Instr, TgtWr, PCWr, PCWrCond, Zero, BrNe, PCSrc, RegA,
        output PC, PCAdd4, Target, JAddr, Phase, AddrErr
    );
endinterface

// File: rtl/br_target_calc.sv
// Branch target adder: PCAdd4 + (sign-extended imm16 << 2), wrapping mod 2^32.
// Latency: combinational. Backpressure: none.
// The caller registers the result.
module br_target_calc (
    input  logic [15:0] imm16,
    input  logic [31:0] pc_add4,
    output logic [31:0] target
);
    logic [31:0] offset;

    assign offset = {{14{imm16[15]}}, imm16, 2'b00};
    assign target = pc_add4 + offset;
endmodule

// File: rtl/pc_sequencer.sv
// PC stage: holds PC, latches PC+4 and immediates at fetch, registers branch target, loads next PC.
// Latency: every output is registered; a PC load is visible one edge after the strobe.
// Backpressure: none; strobes are single-cycle level pulses from the controller.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic Clk,
    input  logic Clrn,
    pc_sequencer_if.slave bus
);

    phase_e      phase_q, phase_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_add4_q, pc_add4_d;
    logic [31:0] target_q, target_d;
    logic [25:0] imm26_q, imm26_d;
    logic [15:0] imm16_q, imm16_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] pc_inc;
    logic [31:0] jaddr;
    logic [31:0] br_target;
    logic [31:0] next_pc;
    logic        load;

    br_target_calc u_br_target_calc (
        .imm16   (imm16_q),
        .pc_add4 (pc_add4_q),
        .target  (br_target)
    );

    assign pc_inc = word_inc(pc_q);
    assign jaddr  = {pc_add4_q[31:28], imm26_q, 2'b00};
    assign load   = bus.PCWr | (bus.PCWrCond & (bus.Zero ^ bus.BrNe));

    always_comb begin
        next_pc = pc_inc;
        case (pcsrc_e'(bus.PCSrc))
            PCS_ADD4: next_pc = pc_inc;
            PCS_BR:   next_pc = target_q;
            PCS_J:    next_pc = jaddr;
            PCS_JR:   next_pc = bus.RegA;
            default:  next_pc = pc_inc;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        pc_add4_d  = pc_add4_q;
        target_d   = target_q;
        imm26_d    = imm26_q;
        imm16_d    = imm16_q;
        addr_err_d = addr_err_q;
        phase_d    = phase_q;

        // A misaligned load target leaves the PC untouched and flags the error.
        if (load) begin
            if (next_pc[1:0] != 2'b00) begin
                addr_err_d = 1'b1;
            end else begin
                pc_d = next_pc;
            end
        end

        if (bus.IRWr) begin
            pc_add4_d = pc_inc;
            imm26_d   = bus.Instr[25:0];
            imm16_d   = bus.Instr[15:0];
        end

        if (bus.TgtWr && (phase_q == PH_DECODE)) begin
            target_d = br_target;
        end

        if (bus.IRWr) begin
            phase_d = PH_DECODE;
        end else begin
            case (phase_q)
                PH_FETCH:  phase_d = PH_FETCH;
                PH_DECODE: phase_d = bus.TgtWr ? PH_EXEC : PH_DECODE;
                PH_EXEC:   phase_d = PH_EXEC;
                default:   phase_d = PH_FETCH;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            phase_q    <= PH_FETCH;
            pc_q       <= RESET_PC;
            pc_add4_q  <= RESET_PC + 32'(WORD_BYTES);
            target_q   <= 32'h0;
            imm26_q    <= 26'h0;
            imm16_q    <= 16'h0;
            addr_err_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            pc_q       <= pc_d;
            pc_add4_q  <= pc_add4_d;
            target_q   <= target_d;
            imm26_q    <= imm26_d;
            imm16_q    <= imm16_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.PC      = pc_q;
    assign bus.PCAdd4  = pc_add4_q;
    assign bus.Target  = target_q;
    assign bus.JAddr   = jaddr;
    assign bus.Phase   = phase_q;
    assign bus.AddrErr = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: directed scenarios then randomized strobes,
// checked against an instruction-level model of the PC stage.
module tb_pc_sequencer;

    logic clk;
    logic clrn;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .Clk  (clk),
        .Clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] add4;
        logic [31:0] tgt;
        logic [31:0] jaddr;
        logic [1:0]  ph;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_pc, m_add4, m_tgt;
    logic [25:0] m_imm26;
    logic [15:0] m_imm16;
    int          m_ph;
    bit          m_err;

    function automatic logic [31:0] m_jaddr();
        return (m_add4 & 32'hF000_0000) | ({6'd0, m_imm26} * 4);
    endfunction

    function automatic exp_t cur_exp();
        exp_t e;
        e.pc    = m_pc;
        e.add4  = m_add4;
        e.tgt   = m_tgt;
        e.jaddr = m_jaddr();
        e.ph    = 2'(m_ph);
        e.err   = m_err;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_add4 = 32'h4; m_tgt = 32'h0;
        m_imm26 = '0; m_imm16 = '0; m_ph = 0; m_err = 0;
    endtask

    task automatic model_step(input bit irwr, tgtwr, pcwr, cond, zero, brne,
                              input int src, input logic [31:0] instr, rega);
        logic [31:0] cand, n_pc, n_add4, n_tgt;
        int n_ph;
        bit ld;
        ld = pcwr || (cond && (zero != brne));
        case (src)
            0: cand = m_pc + 32'd4;
            1: cand = m_tgt;
            2: cand = m_jaddr();
            default: cand = rega;
        endcase
        n_pc = m_pc;
        if (ld) begin
            if (cand % 4 != 0) m_err = 1;
            else n_pc = cand;
        end
        n_add4 = irwr ? m_pc + 32'd4 : m_add4;
        n_tgt = m_tgt;
        if (tgtwr && m_ph == 1) n_tgt = m_add4 + 32'(int'($signed(m_imm16)) * 4);
        if (irwr) n_ph = 1;
        else if (m_ph == 1 && tgtwr) n_ph = 2;
        else n_ph = m_ph;
        if (irwr) begin
            m_imm26 = instr[25:0];
            m_imm16 = instr[15:0];
        end
        m_pc = n_pc; m_add4 = n_add4; m_tgt = n_tgt; m_ph = n_ph;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        chk({tag, ".PC"},      bus.PC,              e.pc);
        chk({tag, ".PCAdd4"},  bus.PCAdd4,          e.add4);
        chk({tag, ".Target"},  bus.Target,          e.tgt);
        chk({tag, ".JAddr"},   bus.JAddr,           e.jaddr);
        chk({tag, ".Phase"},   {30'd0, bus.Phase},  {30'd0, e.ph});
        chk({tag, ".AddrErr"}, {31'd0, bus.AddrErr}, {31'd0, e.err});
    endtask

    task automatic rand_inputs();
        bus.IRWr     = 1'($urandom);
        bus.TgtWr    = 1'($urandom);
        bus.PCWr     = 1'($urandom);
        bus.PCWrCond = 1'($urandom);
        bus.Zero     = 1'($urandom);
        bus.BrNe     = 1'($urandom);
        bus.PCSrc    = 2'($urandom);
        bus.Instr    = $urandom;
        bus.RegA     = $urandom;
    endtask

    task automatic zero_inputs();
        bus.IRWr = 0; bus.TgtWr = 0; bus.PCWr = 0; bus.PCWrCond = 0;
        bus.Zero = 0; bus.BrNe = 0; bus.PCSrc = 2'd0; bus.Instr = '0; bus.RegA = '0;
    endtask

    // Asserts reset at a negedge and checks outputs before any clock edge.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        clrn = 1'b0;
        rand_inputs();
        #1;
        model_reset();
        compare_all("async_rst", cur_exp());
        exp_q.push_back(cur_exp());
        for (int i = 1; i < cycles; i++) begin
            @(negedge clk);
            rand_inputs();
            exp_q.push_back(cur_exp());
        end
        @(negedge clk);
        clrn = 1'b1;
        zero_inputs();
        exp_q.push_back(cur_exp());
    endtask

    task automatic step(input bit irwr, tgtwr, pcwr, cond, zero, brne,
                        input int src, input logic [31:0] instr, rega);
        @(negedge clk);
        bus.IRWr = irwr; bus.TgtWr = tgtwr; bus.PCWr = pcwr; bus.PCWrCond = cond;
        bus.Zero = zero; bus.BrNe = brne; bus.PCSrc = 2'(src);
        bus.Instr = instr; bus.RegA = rega;
        model_step(irwr, tgtwr, pcwr, cond, zero, brne, src, instr, rega);
        exp_q.push_back(cur_exp());
    endtask

    // Monitor: outputs settle after each rising edge; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compare_all("cycle", e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clrn = 1'b0;
        zero_inputs();
        model_reset();
        do_reset(4);

        //    irwr tgt pcwr cond zero brne src instr          rega
        step(0, 0, 1, 0, 0, 0, 3, 32'h0,          32'h0000_0100); // jr 0x100
        step(1, 0, 1, 0, 0, 0, 0, 32'h0000_FFFF,  32'h0);         // fetch, imm16=FFFF
        step(0, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0);         // Target=0x100
        step(0, 0, 1, 0, 0, 0, 3, 32'h0,          32'h0000_0300); // move PC away
        step(0, 0, 0, 1, 1, 0, 1, 32'h0,          32'h0);         // beq taken
        step(0, 0, 1, 0, 0, 0, 3, 32'h0,          32'h0000_0300);
        step(0, 0, 0, 1, 0, 0, 1, 32'h0,          32'h0);         // beq not taken
        step(0, 0, 0, 1, 0, 1, 1, 32'h0,          32'h0);         // bne taken
        step(0, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0);         // TgtWr in EXEC ignored
        step(0, 0, 1, 0, 0, 0, 3, 32'h0,          32'h4000_0100);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0000_0040,  32'h0);         // PCAdd4=0x40000104
        step(0, 0, 1, 0, 0, 0, 2, 32'h0,          32'h0);         // j -> 0x40000100
        step(0, 0, 1, 1, 1, 1, 3, 32'h0,          32'h0000_0202); // misaligned jr
        step(0, 0, 1, 0, 0, 0, 3, 32'h0,          32'h0000_0200); // aligned jr
        step(1, 0, 0, 0, 0, 0, 0, 32'h1234_5678,  32'h0);         // enter DECODE
        do_reset(2);                                               // reset mid-DECODE
        step(0, 0, 1, 0, 0, 0, 3, 32'h0,          32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0);         // TgtWr in FETCH ignored
        step(1, 0, 1, 0, 0, 0, 0, 32'h0000_8001,  32'h0);         // wrap to 0
        step(0, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0);         // wrapped branch add
        step(0, 0, 1, 0, 0, 0, 1, 32'h0,          32'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), $urandom,
                     ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
            end
        end

        @(negedge clk);
        zero_inputs();
        @(posedge clk);
        #2;
        chk("queue_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
